mem_row_feeder: RTL and testbench
=================================

# mem_row_feeder

Upstream stage of the matrix-vector multiplier. On a fill request it reads nine consecutive 64-bit words from on-chip memory: words 0–7 are matrix rows 0–7, and word 8 is the vector. It then serializes each word, one byte per cycle, into the nine 8-entry byte FIFOs using a one-hot write select. It reports busy while a fill is in progress and pulses a completion flag when the last byte has been written.

## Interface
- `ADDR_W`, default 32: width of the memory address bus.
- `BASE_ADDR`, default 0: word address of matrix row 0. Word k is read from `BASE_ADDR + k`.
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `fill`  in  1  starts a fill when sampled high in IDLE. Ignored in every other state.
- `memory_busy`  out  1  high in every state except IDLE.
- `fill_done`  out  1  one-cycle pulse after the last byte of word 8 is written.
- `mem_address`  out  ADDR_W  word address of the current read.
- `mem_read`  out  1  read request, held until accepted.
- `mem_waitrequest`  in  1  slave stall. A request is accepted in a cycle where `mem_read`=1 and `mem_waitrequest`=0.
- `mem_readdata`  in  64  read data.
- `mem_readdatavalid`  in  1  `mem_readdata` is valid this cycle.
- `fifo_full`  in  9  full flags of the FIFOs. Bits [7:0] are matrix FIFOs 0–7; bit 8 is the vector FIFO.
- `fifo_addr`  out  9  one-hot write enable. Bit k writes FIFO k.
- `fifo_din`  out  8  byte written to the FIFO selected by `fifo_addr`.

## Operation
- States are IDLE, REQ, WAIT, SHIFT and DONE.
- Internal registers:
  - row counter `row`, 0..8;
  - byte counter `bcnt`, 0..7;
  - 64-bit word register `word`.
- IDLE: `row`=0 and `bcnt`=0. If `fill`=1, go to REQ.
- REQ:
  - Outputs: `mem_read`=1, `mem_address`=`BASE_ADDR+row`, zero-extended.
  - Stay in REQ while `mem_waitrequest`=1.
  - On acceptance, go to WAIT.
- WAIT:
  - `mem_read`=0.
  - When `mem_readdatavalid`=1, load `word` from `mem_readdata`, set `bcnt`=0 and go to SHIFT.
  - `mem_readdatavalid` is ignored in all other states.
- SHIFT:
  - Output byte is `word[63-8*bcnt -: 8]`, i.e. MSB first, so byte 0 is [63:56].
  - If `fifo_full[row]`=0: assert `fifo_addr` = (1 << `row`) and `fifo_din` = the output byte, then increment `bcnt`.
  - If `fifo_full[row]`=1: `fifo_addr`=0 and `bcnt` holds. This is a stall of any length with no byte lost.
  - After the write with `bcnt`=7:
    - if `row`<8, increment `row` and go to REQ;
    - if `row`=8, go to DONE.
- DONE: assert `fill_done` for one cycle, then go to IDLE.
- `fifo_addr` is combinational from state, `row`, `bcnt` and `fifo_full`. It is all-zero outside SHIFT and never has more than one bit set.
- `fifo_din` is 0 whenever `fifo_addr`=0.
- Only one read is outstanding at a time.

## Timing
- Reset values: `memory_busy`=0, `fill_done`=0, `mem_read`=0, `mem_address`=0, `fifo_addr`=0, `fifo_din`=0. State is IDLE; `row`, `bcnt` and `word` are 0.
- `rst` asserted mid-fill forces IDLE immediately, so all outputs drop asynchronously.
  - An in-flight `mem_readdatavalid` arriving after reset is discarded.
  - A partial fill is not resumed; the next `fill` restarts at row 0.
- `fill` sampled at edge 0 gives `mem_read`=1 from cycle 1.
- Per-word cost: 1 REQ cycle + N wait-request cycles + L cycles from acceptance to `readdatavalid` (L≥1) + 8 SHIFT cycles, excluding full stalls.
  - With N=0 and L=1 this is 10 cycles per word.
  - The first `fifo_addr` pulse for row 0 is in cycle 3.
  - `fill_done` is in cycle 91.
  - `memory_busy` is high for cycles 1–91.
- `fill` held high continuously restarts a new fill in the cycle after DONE returns to IDLE. Both `fill` and `fill_done` high in the same cycle do not shorten DONE.
- `fifo_full` rising in the same cycle as a SHIFT write suppresses that write, since `fifo_addr` is combinational.

## Test plan
- Memory word k = {8{k+1}} per byte, zero-latency slave (N=0, L=1), `fifo_full`=0, one-cycle `fill`:
  - 72 writes in order, rows 0..8, each getting 8 bytes of value k+1;
  - `fill_done` in cycle 91;
  - `memory_busy` low again in cycle 92.
- Word 0 = 0x0102030405060708: FIFO 0 receives 01,02,…,08 in consecutive cycles starting at cycle 3, with `fifo_addr`=9'h001 each cycle.
- `mem_waitrequest` held high 3 cycles on row 4, and L=4 on row 6:
  - `mem_address` holds `BASE_ADDR+4` while stalled;
  - the data sequence is unchanged;
  - `fill_done` arrives 6 cycles later than the baseline.
- `fifo_full[2]` forced high for 5 cycles after the 3rd byte of row 2:
  - `fifo_addr`=0 during the stall;
  - the 4th byte (value 0x03 in scenario 1) is written afterwards;
  - no byte is duplicated or dropped.
- `rst` pulsed during SHIFT of row 5, then `fill` reissued:
  - outputs return to reset values;
  - a late `mem_readdatavalid` is ignored;
  - the new fill starts at address `BASE_ADDR` and completes all 72 writes.
- `fill` pulsed again while `memory_busy`=1: no effect on sequence or timing, and exactly one `fill_done` is produced.

Source files
------------

// File: rtl/mem_row_feeder.sv
// Reads nine 64-bit words (eight matrix rows, then the vector) and streams each
// one MSB-first, a byte per cycle, into its own byte FIFO via a one-hot select.
module mem_row_feeder #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fill,
  output logic              memory_busy,
  output logic              fill_done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  input  logic              mem_waitrequest,
  input  logic [63:0]       mem_readdata,
  input  logic              mem_readdatavalid,
  input  logic [8:0]        fifo_full,
  output logic [8:0]        fifo_addr,
  output logic [7:0]        fifo_din
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          row_q, row_d;
  logic [2:0]          bcnt_q, bcnt_d;
  logic [63:0]         word_q, word_d;
  logic                memory_busy_q, memory_busy_d;
  logic                fill_done_q, fill_done_d;
  logic                mem_read_q, mem_read_d;
  logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
  logic                wr_en;

  // Byte idx of the word, counting from the most significant byte.
  function automatic logic [7:0] byte_sel(input logic [63:0] w, input logic [2:0] idx);
    logic [63:0] s;
    s = w << {idx, 3'b000};
    return s[63:56];
  endfunction

  // A full target FIFO blocks the write in the same cycle it rises.
  assign wr_en = (state_q == SHIFT) && !fifo_full[row_q];

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    bcnt_d  = bcnt_q;
    word_d  = word_q;
    case (state_q)
      IDLE: begin
        row_d  = 4'd0;
        bcnt_d = 3'd0;
        if (fill) state_d = REQ;
      end
      REQ: begin
        if (!mem_waitrequest) state_d = WAIT;
      end
      WAIT: begin
        if (mem_readdatavalid) begin
          word_d  = mem_readdata;
          bcnt_d  = 3'd0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (wr_en) begin
          bcnt_d = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) begin
            if (row_q == 4'd8) begin
              state_d = DONE;
            end else begin
              row_d   = row_q + 4'd1;
              state_d = REQ;
            end
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    memory_busy_d = (state_d != IDLE);
    fill_done_d   = (state_d == DONE);
    mem_read_d    = (state_d == REQ);
    mem_address_d = (state_d == REQ) ? BASE_ADDR + ADDR_W'(row_d) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      row_q         <= 4'd0;
      bcnt_q        <= 3'd0;
      word_q        <= 64'd0;
      memory_busy_q <= 1'b0;
      fill_done_q   <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_address_q <= '0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      bcnt_q        <= bcnt_d;
      word_q        <= word_d;
      memory_busy_q <= memory_busy_d;
      fill_done_q   <= fill_done_d;
      mem_read_q    <= mem_read_d;
      mem_address_q <= mem_address_d;
    end
  end

  assign memory_busy = memory_busy_q;
  assign fill_done   = fill_done_q;
  assign mem_read    = mem_read_q;
  assign mem_address = mem_address_q;
  assign fifo_addr   = wr_en ? (9'd1 << row_q) : 9'd0;
  assign fifo_din    = wr_en ? byte_sel(word_q, bcnt_q) : 8'd0;

endmodule

// File: tb/tb_mem_row_feeder.sv
// Bench for mem_row_feeder: behavioural memory slave, FIFO-full driver and an
// expected-write queue built directly from the memory contents.
module tb_mem_row_feeder;

  localparam int          ADDR_W = 32;
  localparam logic [31:0] BASE   = 32'h100;

  logic              clk = 1'b0;
  logic              rst;
  logic              fill;
  logic              memory_busy;
  logic              fill_done;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_read;
  logic              mem_waitrequest;
  logic [63:0]       mem_readdata;
  logic              mem_readdatavalid;
  logic [8:0]        fifo_full;
  logic [8:0]        fifo_addr;
  logic [7:0]        fifo_din;

  always #5 clk = ~clk;

  mem_row_feeder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .fill(fill),
    .memory_busy(memory_busy), .fill_done(fill_done),
    .mem_address(mem_address), .mem_read(mem_read),
    .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
    .mem_readdatavalid(mem_readdatavalid),
    .fifo_full(fifo_full), .fifo_addr(fifo_addr), .fifo_din(fifo_din)
  );

  typedef struct packed {
    logic [3:0] r;
    logic [7:0] b;
  } wr_t;

  int          total = 0;
  int          bad = 0;
  logic [63:0] mem [9];
  int          stall_n [9];
  int          lat [9];
  int          wr_cnt [9];
  wr_t         exp_q [$];
  int          full_mode, fmode, cyc;
  int          req_idx, acc_row, lat_cnt, stall_left, full_left;
  int          nwr, ndone, done_cyc, first_wr, first_rd, last_r0, busy_gap;
  bit          req_seen, running;
  logic        busy_after;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"},  64'(memory_busy), 64'd0);
    check({tag, "_done"},  64'(fill_done),   64'd0);
    check({tag, "_read"},  64'(mem_read),    64'd0);
    check({tag, "_addr"},  64'(mem_address), 64'd0);
    check({tag, "_fsel"},  64'(fifo_addr),   64'd0);
    check({tag, "_fdin"},  64'(fifo_din),    64'd0);
  endtask

  // One clock cycle: drive slave/FIFO inputs at the falling edge, then check.
  task automatic tick();
    wr_t e;
    @(negedge clk);
    cyc++;
    mem_readdatavalid = 1'b0;
    mem_readdata      = {$urandom, $urandom};
    if (lat_cnt > 0) begin
      lat_cnt--;
      if (lat_cnt == 0) begin
        mem_readdatavalid = 1'b1;
        mem_readdata      = mem[acc_row];
      end
    end
    mem_waitrequest = 1'($urandom_range(0, 1));
    if (mem_read) begin
      if (first_rd < 0) first_rd = cyc;
      check("rd_addr", 64'(mem_address), 64'(BASE + 32'(req_idx)));
      check("one_outstanding", 64'(lat_cnt), 64'd0);
      if (!req_seen) begin
        stall_left = (req_idx < 9) ? stall_n[req_idx] : 0;
        req_seen   = 1'b1;
      end
      if (stall_left > 0) begin
        mem_waitrequest = 1'b1;
        stall_left--;
      end else begin
        mem_waitrequest = 1'b0;
        acc_row  = (req_idx < 9) ? req_idx : 0;
        lat_cnt  = (req_idx < 9) ? lat[req_idx] : 1;
        req_idx++;
        req_seen = 1'b0;
      end
    end
    fill = running && (cyc == 0 || fmode == 2 ||
                       (fmode == 1 && (cyc == 20 || cyc == 55 || cyc == 91)));
    case (full_mode)
      1: begin
        fifo_full = (full_left > 0) ? 9'h004 : 9'h000;
        if (full_left > 0) full_left--;
      end
      2: fifo_full = 9'($urandom) & 9'($urandom);
      default: fifo_full = 9'h000;
    endcase
    #1;
    check("onehot", 64'($onehot0(fifo_addr)), 64'd1);
    if (fifo_addr == 9'd0) begin
      check("din_idle", 64'(fifo_din), 64'd0);
    end else begin
      check("wr_blocked", 64'(fifo_addr & fifo_full), 64'd0);
      if (exp_q.size() == 0) begin
        check("extra_write", 64'(fifo_addr), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_sel",  64'(fifo_addr), 64'(9'd1 << e.r));
        check("wr_byte", 64'(fifo_din),  64'(e.b));
        nwr++;
        wr_cnt[e.r]++;
        if (first_wr < 0) first_wr = cyc;
        if (e.r == 4'd0) last_r0 = cyc;
        if (full_mode == 1 && e.r == 4'd2 && wr_cnt[2] == 3) full_left = 5;
      end
    end
    if (running) begin
      if (cyc >= 1 && done_cyc < 0 && !memory_busy) busy_gap++;
      if (done_cyc >= 0 && cyc == done_cyc + 1) busy_after = memory_busy;
      if (fill_done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = cyc;
        req_idx = 0;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fill = 1'b0;
    mem_readdatavalid = 1'b0;
    mem_waitrequest = 1'b0;
    fifo_full = 9'd0;
    lat_cnt = 0;
    req_seen = 1'b0;
    running = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_fill(input int fm, input int exp_done, input bit chk_r0, input bit abort5);
    wr_t e;
    exp_q.delete();
    for (int k = 0; k < 9; k++) begin
      for (int b = 0; b < 8; b++) begin
        e.r = 4'(k);
        e.b = mem[k][63-8*b -: 8];
        exp_q.push_back(e);
      end
    end
    foreach (wr_cnt[i]) wr_cnt[i] = 0;
    req_idx = 0; req_seen = 1'b0; lat_cnt = 0; stall_left = 0; full_left = 0;
    nwr = 0; ndone = 0; done_cyc = -1; first_wr = -1; first_rd = -1; last_r0 = -1;
    busy_gap = 0; busy_after = 1'bx;
    fmode = fm; running = 1'b1; cyc = -1;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (abort5 && wr_cnt[5] == 3) break;
      if (done_cyc >= 0 && cyc >= done_cyc + 1) break;
    end
    if (fm != 2) running = 1'b0;
    if (abort5) begin
      check("abort_point", 64'(wr_cnt[5]), 64'd3);
    end else begin
      check("done_seen", 64'(done_cyc >= 0), 64'd1);
      if (exp_done >= 0) check("done_cycle", 64'(done_cyc), 64'(exp_done));
      check("done_count", 64'(ndone), 64'd1);
      check("busy_after_done", 64'(busy_after), 64'd0);
      check("busy_gap", 64'(busy_gap), 64'd0);
      check("write_count", 64'(nwr), 64'd72);
      check("left_over", 64'(exp_q.size()), 64'd0);
      if (chk_r0) begin
        check("first_read", 64'(first_rd), 64'd1);
        check("first_write", 64'(first_wr), 64'd3);
        check("last_row0", 64'(last_r0), 64'd10);
      end
    end
  endtask

  task automatic base_mem();
    for (int k = 0; k < 9; k++) mem[k] = {8{8'(k + 1)}};
  endtask

  task automatic default_slave();
    for (int k = 0; k < 9; k++) begin
      stall_n[k] = 0;
      lat[k] = 1;
    end
  endtask

  initial begin
    int exp_done;
    rst = 1'b1; fill = 1'b0; mem_waitrequest = 1'b0; mem_readdata = 64'd0;
    mem_readdatavalid = 1'b0; fifo_full = 9'd0;
    full_mode = 0; fmode = 0; cyc = 0; running = 1'b0;
    default_slave();
    base_mem();
    #2;
    check_reset("por");
    do_reset();

    // Baseline: word k = {8{k+1}}, zero-latency slave.
    run_fill(0, 91, 1'b1, 1'b0);

    // Distinct bytes in word 0 to pin down MSB-first order.
    for (int k = 1; k < 9; k++) mem[k] = {$urandom, $urandom};
    mem[0] = 64'h0102030405060708;
    run_fill(0, 91, 1'b1, 1'b0);

    // Wait-request stall on row 4, longer read latency on row 6.
    base_mem();
    stall_n[4] = 3;
    lat[6] = 4;
    run_fill(0, 97, 1'b1, 1'b0);
    default_slave();

    // FIFO 2 full for 5 cycles after its 3rd byte.
    full_mode = 1;
    run_fill(0, 96, 1'b1, 1'b0);
    full_mode = 0;

    // Asynchronous reset in the middle of row 5, then a stray read-data beat.
    for (int k = 0; k < 9; k++) mem[k] = {$urandom, $urandom};
    run_fill(0, -1, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    check_reset("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    mem_readdatavalid = 1'b1;
    mem_readdata = '1;
    @(negedge clk);
    mem_readdatavalid = 1'b0;
    #1;
    check("late_valid_busy", 64'(memory_busy), 64'd0);
    check("late_valid_fsel", 64'(fifo_addr), 64'd0);
    tick();
    tick();
    check_reset("after_late");
    run_fill(0, 91, 1'b1, 1'b0);

    // Extra fill pulses while busy, including one during DONE.
    base_mem();
    run_fill(1, 91, 1'b1, 1'b0);

    // Fill held high: a new fill follows right after returning to IDLE.
    run_fill(2, 91, 1'b1, 1'b0);
    tick();
    check("restart_busy", 64'(memory_busy), 64'd1);
    check("restart_read", 64'(mem_read), 64'd1);
    running = 1'b0;
    do_reset();

    // Random data and random slave timing; completion cycle from the cost formula.
    for (int n = 0; n < 2; n++) begin
      exp_done = 91;
      for (int k = 0; k < 9; k++) begin
        mem[k] = {$urandom, $urandom};
        stall_n[k] = $urandom_range(0, 3);
        lat[k] = $urandom_range(1, 5);
        exp_done += stall_n[k] + lat[k] - 1;
      end
      run_fill(0, exp_done, 1'b0, 1'b0);
    end

    // Random data, random slave timing and random FIFO-full back-pressure.
    full_mode = 2;
    for (int n = 0; n < 2; n++) begin
      for (int k = 0; k < 9; k++) begin
        mem[k] = {$urandom, $urandom};
        stall_n[k] = $urandom_range(0, 3);
        lat[k] = $urandom_range(1, 5);
      end
      run_fill(0, -1, 1'b0, 1'b0);
    end
    full_mode = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
